keypad_unit: RTL and testbench

- Scans the 4x4 matrix keypad and debounces key presses.
- Emits a single-cycle key code on key_coord, encoded {col_val, row_val} with active-low one-hot nibbles, for input_unit directly downstream.
- input_unit reacts to key_coord on every posedge, so each physical press yields exactly one non-idle code, and idle is 8'hFF.
- key_coord is updated on negedge clk so that input_unit samples a settled value on posedge.

---
 rtl/keypad_unit.sv | 86 ++++++++
 tb/tb_keypad_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_unit.sv
// keypad_unit: 4x4 matrix keypad scanner with debounce, emitting one key code per press
module keypad_unit #(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [7:0] key_coord,
    output logic       key_held
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

    state_t        state, state_nx;
    logic [3:0]    col_meta, col_sync, col_low;
    logic [SW-1:0] scan_cnt, scan_nx;
    logic [DW-1:0] deb_cnt, deb_nx;
    logic [7:0]    cand;
    logic          report, report_nx;
    logic          one_low, scan_last, match, idle, deb_last, counting, latch, rotate;

    always_comb begin
        col_low   = ~col_sync;
        one_low   = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
        scan_last = scan_cnt == SCAN_LAST;
        deb_last  = deb_cnt == DEB_LAST;
        match     = col_sync == cand[7:4];
        idle      = col_sync == 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SCAN;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            SCAN:     state_nx = (scan_last && one_low) ? DEBOUNCE : SCAN;
            DEBOUNCE: state_nx = !match ? SCAN : (deb_last ? RELEASE : DEBOUNCE);
            RELEASE:  state_nx = (idle && deb_last) ? SCAN : RELEASE;
            default:  state_nx = SCAN;
        endcase
    end

    always_comb begin
        counting  = (state == DEBOUNCE && match) || (state == RELEASE && idle);
        latch     = state == SCAN && scan_last && one_low;
        rotate    = (state == SCAN && scan_last && !one_low) || (state != SCAN && state_nx == SCAN);
        report_nx = state == DEBOUNCE && state_nx == RELEASE;
        deb_nx    = (state_nx != state || !counting) ? '0 : deb_cnt + DW'(1);
        scan_nx   = (state == SCAN && !scan_last) ? scan_cnt + SW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            row_out  <= 4'b0111;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            cand     <= '0;
            report   <= 1'b0;
            key_held <= 1'b0;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
            row_out  <= rotate ? {row_out[0], row_out[3:1]} : row_out;
            scan_cnt <= scan_nx;
            deb_cnt  <= deb_nx;
            cand     <= latch ? {col_sync, row_out} : cand;
            report   <= report_nx;
            key_held <= state_nx == RELEASE;
        end
    end

    // negedge update so the downstream posedge consumer samples a settled code
    always_ff @(negedge clk or negedge rst_n)
        if (!rst_n) key_coord <= 8'hFF;
        else        key_coord <= report ? cand : 8'hFF;
endmodule

// File: tb/tb_keypad_unit.sv
// tb_keypad_unit: directed and random keypad presses checked against a behavioural keypad reference
module tb_keypad_unit;
    localparam int SC = 4;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_in, row_out;
    logic [7:0]  key_coord;
    logic        key_held;
    logic [15:0] pressed;

    int vectors = 0;
    int errs = 0;
    int npulse = 0;
    logic [7:0] last_code;

    always #5 clk = ~clk;

    keypad_unit #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .col_in(col_in),
        .row_out(row_out), .key_coord(key_coord), .key_held(key_held)
    );

    // physical keypad: a closed key shorts its column to its row while that row is driven low
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[3-r]) col_in[3-c] = 1'b0;
    end

    function automatic logic [15:0] key(input int r, input int c);
        return 16'd1 << (r*4 + c);
    endfunction

    function automatic logic [3:0] rowpat(input int ri);
        return ~(4'b1000 >> ri);
    endfunction

    function automatic int zeros(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    // reference: mode 0 scan, 1 debounce, 2 release; ri = row index, run = consecutive qualifying cycles
    int         m_mode, m_ri, m_t, m_run;
    logic [7:0] m_cand, m_kc;
    logic       m_rep, m_held;
    logic [3:0] m_cs;
    logic [3:0] q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_ri = 0; m_t = 0; m_run = 0;
            m_cand = '0; m_rep = 0; m_held = 0;
            q = {4'hF, 4'hF};
        end else begin
            m_cs = q.pop_front();
            q.push_back(col_in);
            m_rep = 0;
            if (m_mode == 0) begin
                if (m_t == SC - 1) begin
                    m_t = 0;
                    if (zeros(m_cs) == 1) begin
                        m_cand = {m_cs, rowpat(m_ri)};
                        m_mode = 1;
                        m_run = 0;
                    end else m_ri = (m_ri + 1) % 4;
                end else m_t++;
            end else if (m_mode == 1) begin
                if (m_cs == m_cand[7:4]) begin
                    m_run++;
                    if (m_run == DC) begin
                        m_rep = 1; m_held = 1; m_mode = 2; m_run = 0;
                    end
                end else begin
                    m_run = 0; m_mode = 0; m_ri = (m_ri + 1) % 4; m_t = 0;
                end
            end else begin
                if (m_cs == 4'hF) begin
                    m_run++;
                    if (m_run == DC) begin
                        m_held = 0; m_mode = 0; m_ri = (m_ri + 1) % 4; m_t = 0; m_run = 0;
                    end
                end else m_run = 0;
            end
        end
    end

    always @(negedge clk or negedge rst_n)
        m_kc = (!rst_n || !m_rep) ? 8'hFF : m_cand;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("row_out", {4'h0, row_out}, {4'h0, rowpat(m_ri)});
            check("key_held", {7'd0, key_held}, {7'd0, m_held});
            check("key_coord_pos", key_coord, m_kc);
            if (key_coord !== 8'hFF) begin
                npulse++;
                last_code = key_coord;
            end
            @(negedge clk); #1;
            check("key_coord_neg", key_coord, m_kc);
        end
    endtask

    initial begin
        int w;
        int kind;
        pressed = '0;
        last_code = 8'hFF;
        rst_n = 1'b0;
        #12;
        check("reset_row", {4'h0, row_out}, 8'h07);
        check("reset_coord", key_coord, 8'hFF);
        check("reset_held", {7'd0, key_held}, 8'h00);
        @(negedge clk); #2 rst_n = 1'b1;

        npulse = 0;
        run(40);
        check("idle_pulses", 8'(npulse), 8'd0);

        npulse = 0;
        pressed = key(0, 0);
        run(30);
        pressed = '0;
        run(20);
        check("key1_pulses", 8'(npulse), 8'd1);
        check("key1_code", last_code, 8'b0111_0111);

        npulse = 0;
        pressed = key(3, 1);
        run(3);
        pressed = '0;
        run(1);
        pressed = key(3, 1);
        run(43);
        pressed = '0;
        run(20);
        check("key0_pulses", 8'(npulse), 8'd1);
        check("key0_code", last_code, 8'b1011_1110);

        npulse = 0;
        pressed = key(1, 0) | key(1, 1);
        run(40);
        pressed = '0;
        run(20);
        check("multi_pulses", 8'(npulse), 8'd0);

        npulse = 0;
        pressed = key(0, 3);
        run(30);
        pressed = pressed | key(3, 2);
        run(30);
        pressed = '0;
        run(20);
        check("a_hash_pulses", 8'(npulse), 8'd1);
        check("a_code", last_code, 8'b1110_0111);
        npulse = 0;
        pressed = key(3, 2);
        run(30);
        pressed = '0;
        run(20);
        check("hash_pulses", 8'(npulse), 8'd1);
        check("hash_code", last_code, 8'b1101_1110);

        npulse = 0;
        pressed = key(1, 3);
        w = 0;
        while (m_mode != 1 && w < 40) begin
            run(1);
            w++;
        end
        check("b_debounce_reached", {7'd0, w < 40}, 8'd1);
        run(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_row", {4'h0, row_out}, 8'h07);
        check("async_coord", key_coord, 8'hFF);
        check("async_held", {7'd0, key_held}, 8'h00);
        pressed = '0;
        @(negedge clk); #2 rst_n = 1'b1;
        run(40);
        check("b_pulses", 8'(npulse), 8'd0);

        repeat (60) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) pressed = '0;
            else if (kind < 8) pressed = key($urandom_range(0, 3), $urandom_range(0, 3));
            else pressed = key($urandom_range(0, 3), $urandom_range(0, 3)) | key($urandom_range(0, 3), $urandom_range(0, 3));
            run($urandom_range(1, 40));
        end
        pressed = '0;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
